// File: rtl/msw_game_core.sv
// msw_game_core: parametrised Minesweeper controller (bomb placement, cursor, reveal, flags, win/lose).
// Define MSW_FLOOD_EN to compile in the FLOOD state that auto-reveals around zero cells.
module msw_game_core #(
  parameter int          ROWS = 8,
  parameter int          COLS = 8,
  parameter int          BW   = 8,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [BW-1:0]          i_bombs,
  input  logic                   i_str,
  input  logic                   i_move,
  input  logic                   i_select,
  input  logic                   i_mark,
  input  logic [1:0]             i_course,
  output logic [ROWS*COLS*4-1:0] o_board_out,
  output logic [3:0]             o_cur_row,
  output logic [3:0]             o_cur_col,
  output logic [BW-1:0]          o_flags_left,
  output logic [ROWS*COLS-1:0]   o_bomb_map,
  output logic                   o_win,
  output logic                   o_lose,
  output logic [2:0]             o_state_out
);

  localparam int N  = ROWS * COLS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [4:0] ROWS_L = 5'(ROWS);
  localparam logic [4:0] COLS_L = 5'(COLS);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PLACE = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
`ifdef MSW_FLOOD_EN
  localparam logic [2:0] S_FLOOD = 3'd3;
`endif
  localparam logic [2:0] S_WIN   = 3'd4;
  localparam logic [2:0] S_LOSE  = 3'd5;

  localparam logic [3:0] C_HIDDEN = 4'd9;
  localparam logic [3:0] C_FLAG   = 4'd10;
  localparam logic [3:0] C_BOMB   = 4'd11;

  logic [2:0]    r_state;
  logic [15:0]   r_lfsr;
  logic [N-1:0]  r_bomb_map;
  logic [3:0]    r_cell [N];
  logic [3:0]    r_cur_row;
  logic [3:0]    r_cur_col;
  logic [BW-1:0] r_flags_left;
  logic [8:0]    r_target;
  logic [8:0]    r_placed;
  logic [8:0]    r_revealed;
  logic          r_prev_move;
  logic          r_prev_select;
  logic          r_prev_mark;
`ifdef MSW_FLOOD_EN
  logic [IW-1:0] r_scan_idx;
  logic          r_swept_change;
`endif

  logic          w_lfsr_fb;
  logic          w_move_edge;
  logic          w_sel_edge;
  logic          w_mark_edge;
  logic [IW-1:0] w_cur_idx;
  logic [3:0]    w_cur_cell;
  logic [IW-1:0] w_cand_idx;
  logic          w_cand_ok;
  logic [8:0]    w_target;
  logic [8:0]    w_goal;
  logic [3:0]    w_count [N];
  logic [ROWS+1:0][COLS+1:0] w_bpad;

  assign w_lfsr_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_move_edge = i_move & ~r_prev_move;
  assign w_sel_edge  = i_select & ~r_prev_select;
  assign w_mark_edge = i_mark & ~r_prev_mark;
  assign w_cur_idx   = IW'(32'(r_cur_row) * COLS + 32'(r_cur_col));
  assign w_cur_cell  = r_cell[w_cur_idx];
  assign w_cand_idx  = IW'(32'(r_lfsr[3:0]) * COLS + 32'(r_lfsr[7:4]));
  assign w_cand_ok   = ({1'b0, r_lfsr[3:0]} < ROWS_L) && ({1'b0, r_lfsr[7:4]} < COLS_L) &&
                       !r_bomb_map[w_cand_idx];
  assign w_goal      = 9'(N) - r_target;

  always_comb begin
    if (i_bombs == '0)
      w_target = 9'd1;
    else if (32'(i_bombs) > 32'(N - 1))
      w_target = 9'(N - 1);
    else
      w_target = 9'(i_bombs);
  end

  // Zero-padded bomb map so every cell sees eight in-range neighbours.
  genvar gi;
  generate
    for (gi = 0; gi < (ROWS + 2) * (COLS + 2); gi++) begin : g_bpad
      localparam int PR = gi / (COLS + 2);
      localparam int PC = gi % (COLS + 2);
      if (PR == 0 || PR == ROWS + 1 || PC == 0 || PC == COLS + 1) begin : g_edge
        assign w_bpad[PR][PC] = 1'b0;
      end else begin : g_in
        assign w_bpad[PR][PC] = r_bomb_map[(PR - 1) * COLS + PC - 1];
      end
    end

    for (gi = 0; gi < N; gi++) begin : g_cell
      localparam int R = gi / COLS;
      localparam int C = gi % COLS;
      assign w_count[gi] = 4'(w_bpad[R][C])     + 4'(w_bpad[R][C+1])   + 4'(w_bpad[R][C+2]) +
                           4'(w_bpad[R+1][C])   + 4'(w_bpad[R+1][C+2]) +
                           4'(w_bpad[R+2][C])   + 4'(w_bpad[R+2][C+1]) + 4'(w_bpad[R+2][C+2]);
      assign o_board_out[gi*4 +: 4] = r_cell[gi];
    end
  endgenerate

`ifdef MSW_FLOOD_EN
  logic [ROWS+1:0][COLS+1:0] w_zpad;
  logic [N-1:0]              w_zero_adj;
  logic                      w_scan_hit;

  generate
    for (gi = 0; gi < (ROWS + 2) * (COLS + 2); gi++) begin : g_zpad
      localparam int PR = gi / (COLS + 2);
      localparam int PC = gi % (COLS + 2);
      if (PR == 0 || PR == ROWS + 1 || PC == 0 || PC == COLS + 1) begin : g_edge
        assign w_zpad[PR][PC] = 1'b0;
      end else begin : g_in
        assign w_zpad[PR][PC] = (r_cell[(PR - 1) * COLS + PC - 1] == 4'd0);
      end
    end

    for (gi = 0; gi < N; gi++) begin : g_zadj
      localparam int R = gi / COLS;
      localparam int C = gi % COLS;
      assign w_zero_adj[gi] = w_zpad[R][C]   | w_zpad[R][C+1]   | w_zpad[R][C+2] |
                              w_zpad[R+1][C] | w_zpad[R+1][C+2] |
                              w_zpad[R+2][C] | w_zpad[R+2][C+1] | w_zpad[R+2][C+2];
    end
  endgenerate

  assign w_scan_hit = (r_cell[r_scan_idx] == C_HIDDEN) && !r_bomb_map[r_scan_idx] &&
                      w_zero_adj[r_scan_idx];
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state       <= S_IDLE;
      r_lfsr        <= SEED;
      r_bomb_map    <= '0;
      for (int i = 0; i < N; i++) r_cell[i] <= C_HIDDEN;
      r_cur_row     <= '0;
      r_cur_col     <= '0;
      r_flags_left  <= '0;
      r_target      <= '0;
      r_placed      <= '0;
      r_revealed    <= '0;
      r_prev_move   <= 1'b0;
      r_prev_select <= 1'b0;
      r_prev_mark   <= 1'b0;
`ifdef MSW_FLOOD_EN
      r_scan_idx     <= '0;
      r_swept_change <= 1'b0;
`endif
    end else begin
      r_lfsr        <= {r_lfsr[14:0], w_lfsr_fb};
      r_prev_move   <= i_move;
      r_prev_select <= i_select;
      r_prev_mark   <= i_mark;
      case (r_state)
        S_IDLE, S_WIN, S_LOSE: begin
          if (i_str) begin
            r_state      <= S_PLACE;
            r_bomb_map   <= '0;
            for (int i = 0; i < N; i++) r_cell[i] <= C_HIDDEN;
            r_cur_row    <= '0;
            r_cur_col    <= '0;
            r_flags_left <= '0;
            r_placed     <= '0;
            r_revealed   <= '0;
            r_target     <= w_target;
          end
        end
        S_PLACE: begin
          if (w_cand_ok) begin
            r_bomb_map[w_cand_idx] <= 1'b1;
            r_placed               <= r_placed + 9'd1;
            if (r_placed + 9'd1 == r_target) begin
              r_state      <= S_PLAY;
              r_flags_left <= BW'(r_target);
            end
          end
        end
        S_PLAY: begin
          if (r_revealed == w_goal) begin
            r_state <= S_WIN;
          end else if (w_sel_edge) begin
            if (w_cur_cell == C_HIDDEN) begin
              if (r_bomb_map[w_cur_idx]) begin
                for (int i = 0; i < N; i++)
                  if (r_bomb_map[i]) r_cell[i] <= C_BOMB;
                r_state <= S_LOSE;
              end else begin
                r_cell[w_cur_idx] <= w_count[w_cur_idx];
                r_revealed        <= r_revealed + 9'd1;
`ifdef MSW_FLOOD_EN
                if (w_count[w_cur_idx] == 4'd0) begin
                  r_state        <= S_FLOOD;
                  r_scan_idx     <= '0;
                  r_swept_change <= 1'b0;
                end
`endif
              end
            end
          end else if (w_mark_edge) begin
            if (w_cur_cell == C_HIDDEN && r_flags_left != '0) begin
              r_cell[w_cur_idx] <= C_FLAG;
              r_flags_left      <= r_flags_left - 1'b1;
            end else if (w_cur_cell == C_FLAG) begin
              r_cell[w_cur_idx] <= C_HIDDEN;
              r_flags_left      <= r_flags_left + 1'b1;
            end
          end else if (w_move_edge) begin
            case (i_course)
              2'b00: if (r_cur_row != 4'd0) r_cur_row <= r_cur_row - 4'd1;
              2'b01: if ({1'b0, r_cur_row} != ROWS_L - 5'd1) r_cur_row <= r_cur_row + 4'd1;
              2'b10: if (r_cur_col != 4'd0) r_cur_col <= r_cur_col - 4'd1;
              default: if ({1'b0, r_cur_col} != COLS_L - 5'd1) r_cur_col <= r_cur_col + 4'd1;
            endcase
          end
        end
`ifdef MSW_FLOOD_EN
        // One cell per cycle; sweeps repeat until a full pass reveals nothing.
        S_FLOOD: begin
          if (w_scan_hit) begin
            r_cell[r_scan_idx] <= w_count[r_scan_idx];
            r_revealed         <= r_revealed + 9'd1;
          end
          if (r_scan_idx == IW'(N - 1)) begin
            if (r_swept_change || w_scan_hit) begin
              r_scan_idx     <= '0;
              r_swept_change <= 1'b0;
            end else begin
              r_state <= S_PLAY;
            end
          end else begin
            r_scan_idx     <= r_scan_idx + 1'b1;
            r_swept_change <= r_swept_change | w_scan_hit;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_cur_row    = r_cur_row;
  assign o_cur_col    = r_cur_col;
  assign o_flags_left = r_flags_left;
  assign o_bomb_map   = r_bomb_map;
  assign o_win        = (r_state == S_WIN);
  assign o_lose       = (r_state == S_LOSE);
  assign o_state_out  = r_state;

endmodule

// File: doc/msw_game_core.md
# msw_game_core

Parametrised Minesweeper game engine. It replaces the fixed 8x8 board/bomb/move/select datapath with one clocked controller. The controller owns bomb placement, cursor movement, reveal, flagging, optional zero-cell flood fill and win/lose detection. It sits between the debounced button/switch inputs and the display renderer, and exports a flat per-cell status vector.

## Interface
- `ROWS`, 8, board rows, 4..16
- `COLS`, 8, board columns, 4..16
- `BW`, 8, width of `bombs` and `flags_left`
- `SEED`, 16'hACE1, LFSR reset value, must be nonzero
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset; clears every register
- `bombs`  in  BW  requested bomb count, sampled on accepted `str`
- `str`  in  1  start/restart level
- `move`, `select`, `mark`  in  1 each  button levels, already synchronised
- `course`  in  2  move direction: 00 up, 01 down, 10 left, 11 right
- `board_out`  out  ROWS*COLS*4  cell r,c at bits [(r*COLS+c)*4 +: 4]
- `cur_row`, `cur_col`  out  4 each  cursor position
- `flags_left`  out  BW  bomb count minus flags placed (signed wrap not allowed, see Operation)
- `bomb_map`  out  ROWS*COLS  placed bombs, for verification
- `win`, `lose`  out  1 each  game result
- `state_out`  out  3  FSM state code

## Operation
- Cell codes: 0..8 revealed with that neighbour-bomb count; 9 hidden; 10 flagged; 11 bomb shown.
- Neighbour counts are combinational from `bomb_map` over the 8 neighbours, clipped at board edges.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, loaded with SEED on reset, steps every cycle in all states.
- FSM codes: IDLE=0, PLACE=1, PLAY=2, FLOOD=3, WIN=4, LOSE=5.
- IDLE/WIN/LOSE + `str`=1 -> PLACE. Entering PLACE does the following:
  - clears `bomb_map`, all cells to hidden, flags and revealed counter;
  - moves the cursor to (0,0);
  - latches target = clamp(`bombs`, 1, ROWS*COLS-1).
- PLACE: each cycle the candidate is row=lfsr[3:0], col=lfsr[7:4].
  - The candidate is placed if row<ROWS, col<COLS and there is no bomb there.
  - When the placed count reaches target -> PLAY. `flags_left` = target.
- PLAY: actions fire on a rising edge of the button level (previous sample 0, current 1). Priority is select > mark > move; lower-priority edges in the same cycle are dropped.
  - move: cursor steps one cell in `course`; saturates at edges, no wrap.
  - mark on hidden: cell becomes flagged, `flags_left`-1. Mark on flagged: cell becomes hidden, `flags_left`+1. Ignored when `flags_left`=0 and the cell is hidden. Ignored on revealed cells.
  - select on flagged or revealed: ignored.
  - select on a hidden bomb: every bomb cell becomes code 11 -> LOSE.
  - select on a hidden safe cell: reveal it and increment the revealed counter. With a count of 0 and flood enabled -> FLOOD; otherwise stay in PLAY.
- FLOOD: scans cells in index order, one per cycle.
  - A hidden, unflagged, non-bomb cell adjacent to a revealed 0 cell is revealed in that cycle.
  - At the end of a sweep with no reveals -> PLAY. Otherwise start another sweep.
  - Button edges are dropped in PLACE and FLOOD.
- Win check in PLAY: revealed counter = ROWS*COLS − target -> WIN.
- `win` is 1 only in WIN. `lose` is 1 only in LOSE.
- In WIN and LOSE the board is frozen; only `str` acts.
- `str` is ignored in PLACE, PLAY and FLOOD.

## Timing
- Reset values:
  - `state_out`=0; cursor (0,0);
  - all cells 9; `bomb_map`=0;
  - `flags_left`=0; `win`=`lose`=0;
  - edge registers 0.
- Reset mid-game aborts immediately, with no residual state.
- A button edge is detected and acted on at the same rising clock edge; `board_out` and the cursor reflect it after that edge.
- Latencies:
  - IDLE to PLACE: 1 cycle.
  - PLACE: at least target cycles, variable.
  - Win transition: one cycle after the last reveal, or one cycle after FLOOD exit.
- A FLOOD sweep is ROWS*COLS cycles. The final no-change sweep is included.

## Configuration
- `MSW_FLOOD_EN` defined: the FLOOD state and auto-reveal are compiled in.
- `MSW_FLOOD_EN` undefined:
  - the FLOOD state is removed, and state code 3 is unused;
  - selecting a 0 cell reveals only that cell and stays in PLAY.

## Test plan
- Reset with `rst`=0 mid-PLAY, then release:
  - all cells 9, state 0, `win`=`lose`=0;
  - then `str` with `bombs`=10 -> PLAY with popcount(`bomb_map`)=10 and `flags_left`=10.
- `bombs`=0 and `bombs`=200 on 8x8 -> target clamps to 1 and 63 respectively.
- Cursor at (0,0) with `course`=00, then 10, one press each:
  - cursor stays (0,0);
  - 8 presses with `course`=11 -> `cur_col`=7.
- Held `select` lasting 20 cycles gives one action. Select and mark rising together -> only the reveal occurs.
- Mark a hidden cell: code 10, `flags_left`-1. Mark again: code 9, restored. Select on a flagged cell: no change.
- Model-driven game with SEED=16'hACE1:
  - select a bomb -> LOSE, all bombs at 11, `lose`=1;
  - new game with all safe cells revealed -> `win`=1;
  - select a 0 cell -> flood reveals the model-predicted region (with `MSW_FLOOD_EN`), or that single cell (without it).
